// File: rtl/barrel_pkg.sv
// Shared constants for the pipelined barrel shifter: operation mode encodings.
package barrel_pkg;

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_SRL = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter pipeline stage: optional shift/rotate by 2^STAGE followed by
// the stage register carrying valid, amount, mode, original sign and a zero flag.
module shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGE = 0,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic [1:0]       mode_i,
  input  logic             sign_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output logic [1:0]       mode_o,
  output logic             sign_o,
  output logic             zero_o
);

  localparam int SH = 1 << STAGE;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [SHW-1:0]   amt_d, amt_q;
  logic [1:0]       mode_d, mode_q;
  logic             sign_d, sign_q;
  logic             zero_d, zero_q;

  always_comb begin
    data_d  = data_i;
    valid_d = valid_i;
    amt_d   = amt_i;
    mode_d  = mode_i;
    sign_d  = sign_i;
    if (amt_i[STAGE]) begin
      case (mode_i)
        MODE_ROR: data_d = (data_i >> SH) | (data_i << (WIDTH - SH));
        MODE_ROL: data_d = (data_i << SH) | (data_i >> (WIDTH - SH));
        MODE_SRL: data_d = data_i >> SH;
        // SRA fills from the sign of the original operand, carried alongside
        default:  data_d = (data_i >> SH) | (sign_i ? ~({WIDTH{1'b1}} >> SH) : '0);
      endcase
    end
    zero_d = (data_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;
  assign sign_o  = sign_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator: log2(WIDTH) stages sharing one enable so the
// whole pipe advances or holds together under output backpressure.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic             adv;
  logic             v_s    [SHW+1];
  logic [WIDTH-1:0] d_s    [SHW+1];
  logic [SHW-1:0]   amt_s  [SHW+1];
  logic [1:0]       mode_s [SHW+1];
  logic             sign_s [SHW+1];
  logic [SHW-1:0]   zero_v;
  logic             unused_tail;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  assign v_s[0]    = in_valid;
  assign d_s[0]    = in_data;
  assign amt_s[0]  = in_amt;
  assign mode_s[0] = in_mode;
  assign sign_s[0] = in_data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .STAGE(k)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .valid_i (v_s[k]),
      .data_i  (d_s[k]),
      .amt_i   (amt_s[k]),
      .mode_i  (mode_s[k]),
      .sign_i  (sign_s[k]),
      .valid_o (v_s[k+1]),
      .data_o  (d_s[k+1]),
      .amt_o   (amt_s[k+1]),
      .mode_o  (mode_s[k+1]),
      .sign_o  (sign_s[k+1]),
      .zero_o  (zero_v[k])
    );
  end

  assign out_valid = v_s[SHW];
  assign out_data  = d_s[SHW];
  assign out_zero  = zero_v[SHW-1];

  // Sideband leaving the last stage and the intermediate zero flags have no consumer
  assign unused_tail = ^{amt_s[SHW], mode_s[SHW], sign_s[SHW], zero_v};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed self-checking bench for barrel_shifter_pipe at WIDTH=8 and WIDTH=32.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv, ir, ov, ordy, oz;
  logic [7:0] id, od;
  logic [2:0] ia;
  logic [1:0] im;

  logic        iv32, ir32, ov32, ordy32, oz32;
  logic [31:0] id32, od32;
  logic [4:0]  ia32;
  logic [1:0]  im32;

  int tests_run = 0;
  int tests_failed = 0;

  barrel_shifter_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir), .in_data(id), .in_amt(ia), .in_mode(im),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_zero(oz)
  );

  barrel_shifter_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_amt(ia32), .in_mode(im32),
    .out_valid(ov32), .out_ready(ordy32), .out_data(od32), .out_zero(oz32)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = 0; id = '0; ia = '0; im = '0; ordy = 1'b1;
    iv32 = 0; id32 = '0; ia32 = '0; im32 = '0; ordy32 = 1'b1;
    #2;
    tests_run++;
    if (ov !== 1'b0 || od !== 8'h00 || oz !== 1'b0 || ir !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset8: ov=%b od=%h oz=%b ir=%b, want 0 00 0 1", ov, od, oz, ir);
    end
    tests_run++;
    if (ov32 !== 1'b0 || od32 !== 32'h0 || oz32 !== 1'b0 || ir32 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset32: ov=%b od=%h oz=%b ir=%b, want 0 0 0 1", ov32, od32, oz32, ir32);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_modes();
    logic [7:0] exp_v [4] = '{8'hD2, 8'hB4, 8'h12, 8'hF2};
    for (int m = 0; m < 4; m++) begin
      iv = 1'b1; id = 8'h96; ia = 3'd3; im = 2'(m);
      step();
      iv = 1'b0;
      step();
      tests_run++;
      if (ov !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_early mode=%0d: out_valid=%b, want 0", m, ov);
      end
      step();
      tests_run++;
      if (ov !== 1'b1 || od !== exp_v[m] || oz !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic mode=%0d: ov=%b od=%h oz=%b, want 1 %h 0", m, ov, od, oz, exp_v[m]);
      end
      step();
    end
  endtask

  task automatic test_amt_zero();
    for (int m = 0; m < 4; m++) begin
      iv = 1'b1; id = 8'hA5; ia = 3'd0; im = 2'(m);
      step();
      iv = 1'b0;
      step();
      step();
      tests_run++;
      if (ov !== 1'b1 || od !== 8'hA5) begin
        tests_failed++;
        $display("FAIL amt_zero mode=%0d: ov=%b od=%h, want 1 a5", m, ov, od);
      end
      step();
    end
  endtask

  task automatic test_streaming();
    logic [7:0] exp_v [8] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    for (int t = 0; t < 12; t++) begin
      iv = (t < 8); id = 8'h01; ia = 3'(t); im = 2'b00;
      step();
      tests_run++;
      if (t >= 2 && t <= 9) begin
        if (ov !== 1'b1 || od !== exp_v[t-2] || oz !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream t=%0d: ov=%b od=%h oz=%b, want 1 %h 0", t, ov, od, oz, exp_v[t-2]);
        end
      end else if (ov !== 1'b0) begin
        tests_failed++;
        $display("FAIL stream_idle t=%0d: out_valid=%b, want 0", t, ov);
      end
    end
    iv = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_v [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    int sent = 0;
    int recv = 0;
    bit saw_ir_low = 0;
    bit stall_seen = 0;
    logic [7:0] stall_val = '0;
    for (int c = 0; c < 40; c++) begin
      ordy = !(c >= 4 && c < 9);
      iv = (sent < 10); id = 8'h01; ia = 3'(sent % 8); im = 2'b01;
      #1;
      if (!ordy && !ir) saw_ir_low = 1;
      if (ov && !ordy) begin
        if (stall_seen) begin
          tests_run++;
          if (od !== stall_val) begin
            tests_failed++;
            $display("FAIL bp_hold c=%0d: od=%h, want %h", c, od, stall_val);
          end
        end
        stall_val = od;
        stall_seen = 1;
      end
      if (ov && ordy) begin
        tests_run++;
        if (recv >= 10) begin
          tests_failed++;
          $display("FAIL bp_extra c=%0d: item %0d od=%h, want none", c, recv, od);
        end else if (od !== exp_v[recv]) begin
          tests_failed++;
          $display("FAIL bp_data item=%0d: od=%h, want %h", recv, od, exp_v[recv]);
        end
        recv++;
      end
      if (iv && ir) sent++;
      step();
    end
    iv = 1'b0; ordy = 1'b1;
    tests_run++;
    if (recv != 10 || sent != 10) begin
      tests_failed++;
      $display("FAIL bp_count: sent=%0d recv=%0d, want 10 10", sent, recv);
    end
    tests_run++;
    if (!saw_ir_low) begin
      tests_failed++;
      $display("FAIL bp_in_ready: in_ready never 0 during stall, want 0");
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      iv = 1'b1; id = 8'h01; ia = 3'(i); im = 2'b00;
      step();
    end
    iv = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ov !== 1'b0 || od !== 8'h00 || ir !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid: ov=%b od=%h ir=%b, want 0 00 1", ov, od, ir);
    end
    step();
    step();
    iv = 1'b1; id = 8'h0F; ia = 3'd4; im = 2'b00;
    #1;
    rst_n = 1'b1;
    step();
    iv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (i == 0 && ov !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_stale: out_valid=%b, want 0", ov);
      end else if (i == 1 && (ov !== 1'b1 || od !== 8'hF0)) begin
        tests_failed++;
        $display("FAIL rst_first_accept: ov=%b od=%h, want 1 f0", ov, od);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (ov !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_after cyc=%0d: out_valid=%b, want 0", i, ov);
      end
    end
  endtask

  task automatic test_width32();
    logic [31:0] vin  [3] = '{32'h80000000, 32'h80000000, 32'h00000001};
    logic [4:0]  vamt [3] = '{5'd31, 5'd31, 5'd1};
    logic [1:0]  vmod [3] = '{2'b11, 2'b10, 2'b10};
    logic [31:0] vexp [3] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    logic        vz   [3] = '{1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 3; v++) begin
      iv32 = 1'b1; id32 = vin[v]; ia32 = vamt[v]; im32 = vmod[v];
      step();
      iv32 = 1'b0;
      step();
      step();
      step();
      tests_run++;
      if (ov32 !== 1'b0) begin
        tests_failed++;
        $display("FAIL w32_early v=%0d: out_valid=%b, want 0", v, ov32);
      end
      step();
      tests_run++;
      if (ov32 !== 1'b1 || od32 !== vexp[v] || oz32 !== vz[v]) begin
        tests_failed++;
        $display("FAIL w32 v=%0d: ov=%b od=%h oz=%b, want 1 %h %b", v, ov32, od32, oz32, vexp[v], vz[v]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_modes();
    test_amt_zero();
    test_streaming();
    test_backpressure();
    test_reset_mid();
    test_width32();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width; power of two, 2..64.
REQ-002 SHALL have derived localparam SHW = log2(WIDTH): shift-amount width and number of pipeline stages.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: in_data/in_amt/in_mode valid this cycle.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the input this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: operand.
REQ-008 SHALL have port in_amt, input, SHW: shift/rotate amount, 0..WIDTH-1.
REQ-009 SHALL have port in_mode, input, 2: 00 ROR, 01 ROL, 10 SRL (logical right), 11 SRA (arithmetic right).
REQ-010 SHALL have port out_valid, output, 1: out_data/out_zero valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the output.
REQ-012 SHALL have port out_data, output, WIDTH: result.
REQ-013 SHALL have port out_zero, output, 1: high when out_data == 0.

Function
REQ-014 SHALL define ROR as out_data[i] = in_data[(i+amt) mod WIDTH], which equals the 8-bit rotator behaviour when WIDTH=8.
REQ-015 SHALL define ROL as out_data[(i+amt) mod WIDTH] = in_data[i].
REQ-016 SHALL define SRL as a right shift with zero fill, and SRA as a right shift filled with in_data[WIDTH-1].
REQ-017 SHALL implement SHW stages; stage k conditionally applies a shift/rotate by 2^k according to amt bit k; each stage ends in a register.
REQ-018 SHALL carry valid, the remaining amt bits, the mode and, for SRA, the original sign bit with the data through every stage register.
REQ-019 SHALL have a latency of exactly SHW cycles from the in_valid&&in_ready edge to out_valid, with no stalls.
REQ-020 SHALL sustain a throughput of one result per cycle while out_ready is held high.
REQ-021 SHALL derive a single pipeline enable: adv = !out_valid || out_ready; in_ready = adv; all stage registers load only when adv.
REQ-022 SHALL hold all stages when adv=0; out_data/out_zero SHALL remain stable while out_valid && !out_ready.
REQ-023 SHALL shift bubbles (valid=0) like data and SHALL NOT collapse them.
REQ-024 SHALL pass in_data through unchanged when amt=0, for every mode.
REQ-025 SHALL register out_zero in the same final register as out_data, with no added latency.
REQ-026 SHALL accept a new input in the same cycle the final result is accepted (in_valid, out_valid, out_ready all high) with no lost or duplicated item.
REQ-027 SHALL produce no out_valid pulses for cycles in which in_valid=0.

Reset
REQ-028 SHALL, while rst_n=0, immediately clear every stage valid bit and drive out_valid=0, out_data=0, out_zero=0, and in_ready=1.
REQ-029 SHALL discard in-flight items on reset mid-operation; no result SHALL appear after reset release for inputs accepted before it.
REQ-030 SHALL accept input on the first rising clk edge after rst_n deasserts.

Structure
REQ-031 SHALL place the mode encodings (ROR, ROL, SRL, SRA) as named constants in shared package barrel_pkg.
REQ-032 SHALL implement one stage as sub-module shift_stage, parameters WIDTH and STAGE, containing that stage's combinational shift and pipeline register, instantiated SHW times in a generate loop.
REQ-033 SHALL not use latches; all combinational logic SHALL be fully assigned.

Verification
REQ-034 Bench SHALL cover basic modes: WIDTH=8, in_data=0x96, amt=3, out_ready=1 -> ROR 0xD2, ROL 0xB4, SRL 0x12, SRA 0xF2, each exactly 3 cycles after acceptance.
REQ-035 Bench SHALL cover streaming: 8 back-to-back ROR inputs 0x01, amt 0..7 -> outputs 0x01,0x80,0x40,...,0x02 on 8 consecutive cycles; amt=0 passthrough; out_zero=0 throughout.
REQ-036 Bench SHALL cover backpressure: out_ready=0 for 5 cycles while streaming -> in_ready=0 once the pipe is full, out_data held stable, no loss or duplication after release.
REQ-037 Bench SHALL cover reset mid-stream: rst_n pulsed low with 3 items in flight -> out_valid=0 immediately, no stale result after release.
REQ-038 Bench SHALL cover WIDTH=32: 0x80000000 SRA 31 -> 0xFFFFFFFF; SRL 31 -> 0x00000001; 0x00000001 SRL 1 -> 0, out_zero=1; latency 5.
